// File: rtl/pass_engine.sv
// pass_engine
//   Runs one sequencer pass: picks up the one-hot pass select (forward 0,
//   forward 1, backward), walks that pass's buffer address range one beat
//   per enabled, unstalled cycle, and hands back the matching end strobe.
//
// Ports
//   clk_i, rst_i           clock (rising edge), async active-low reset
//   en_i                   global enable; low freezes all state and outputs
//   f0_pass_i/f1_pass_i/b_pass_i  pass select levels from the sequencer
//   stall_i                datapath back-pressure, blocks beat issue
//   addr_o                 current beat address
//   valid_o                beat issued this cycle
//   dir_o                  0 ascending (forward), 1 descending (backward)
//   pass_id_o              00 none, 01 f0, 10 f1, 11 b
//   f0_end_o/f1_end_o/b_end_o  pass-complete strobes
//   busy_o                 walking a range
//   err_o                  sticky: more than one select seen in IDLE
module pass_engine #(
    parameter int ADDR_W = 4,
    parameter int F0_LEN = 8,
    parameter int F1_LEN = 8,
    parameter int B_LEN  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              f0_pass_i,
    input  logic              f1_pass_i,
    input  logic              b_pass_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    output logic              dir_o,
    output logic [1:0]        pass_id_o,
    output logic              f0_end_o,
    output logic              f1_end_o,
    output logic              b_end_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [1:0] PID_NONE = 2'd0;
    localparam logic [1:0] PID_F0   = 2'd1;
    localparam logic [1:0] PID_F1   = 2'd2;
    localparam logic [1:0] PID_B    = 2'd3;

    // LEN may equal 2^ADDR_W, so LEN-1 is the largest value that still fits.
    localparam logic [ADDR_W-1:0] F0_LAST  = ADDR_W'(F0_LEN - 1);
    localparam logic [ADDR_W-1:0] F1_LAST  = ADDR_W'(F1_LEN - 1);
    localparam logic [ADDR_W-1:0] B_FIRST  = ADDR_W'(B_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state;
    logic [2:0]        sel;
    logic              sel_one_hot;
    logic              sel_multi;
    logic              lat_sel;
    logic [ADDR_W-1:0] last_addr;
    logic              at_last;

    assign sel         = {b_pass_i, f1_pass_i, f0_pass_i};
    assign sel_one_hot = (sel != 3'd0) && ((sel & (sel - 3'd1)) == 3'd0);
    assign sel_multi   = (sel != 3'd0) && !sel_one_hot;

    // Select level belonging to the pass currently owned by the engine.
    always_comb begin
        lat_sel = 1'b0;
        case (pass_id_o)
            PID_F0:  lat_sel = f0_pass_i;
            PID_F1:  lat_sel = f1_pass_i;
            PID_B:   lat_sel = b_pass_i;
            default: lat_sel = 1'b0;
        endcase
    end

    // Terminal address of the range; backward passes end at 0.
    always_comb begin
        last_addr = '0;
        case (pass_id_o)
            PID_F0:  last_addr = F0_LAST;
            PID_F1:  last_addr = F1_LAST;
            default: last_addr = '0;
        endcase
    end

    assign at_last = (addr_o == last_addr);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            addr_o    <= '0;
            dir_o     <= 1'b0;
            pass_id_o <= PID_NONE;
            err_o     <= 1'b0;
        end else if (en_i) begin
            case (state)
                S_IDLE: begin
                    if (sel_one_hot) begin
                        state     <= S_RUN;
                        dir_o     <= b_pass_i;
                        addr_o    <= b_pass_i ? B_FIRST : '0;
                        pass_id_o <= b_pass_i  ? PID_B  :
                                     f1_pass_i ? PID_F1 : PID_F0;
                    end else if (sel_multi) begin
                        err_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lat_sel) begin
                        // Abort: sequencer withdrew the pass mid-range.
                        state     <= S_IDLE;
                        addr_o    <= '0;
                        dir_o     <= 1'b0;
                        pass_id_o <= PID_NONE;
                    end else if (!stall_i) begin
                        // Last beat leaves the address in place so the
                        // counter can never wrap.
                        if (at_last)
                            state <= S_DONE;
                        else if (dir_o)
                            addr_o <= addr_o - ADDR_ONE;
                        else
                            addr_o <= addr_o + ADDR_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_HOLD;
                end
                default: begin
                    // HOLD: wait for the select to drop so the same pass
                    // is never re-run off a lingering level.
                    if (!lat_sel) begin
                        state     <= S_IDLE;
                        addr_o    <= '0;
                        dir_o     <= 1'b0;
                        pass_id_o <= PID_NONE;
                    end
                end
            endcase
        end
    end

    // Beat issue must react to stall/enable in the same cycle; it does not
    // depend on the select inputs.
    assign valid_o  = (state == S_RUN) && en_i && !stall_i;
    assign busy_o   = (state == S_RUN);
    assign f0_end_o = (state == S_DONE) && (pass_id_o == PID_F0);
    assign f1_end_o = (state == S_DONE) && (pass_id_o == PID_F1);
    assign b_end_o  = (state == S_DONE) && (pass_id_o == PID_B);

endmodule

// File: doc/pass_engine.md
# pass_engine

Executes the work of one sequencer pass: it receives the one-hot pass-select levels (forward 0, forward 1, backward) from the pass sequencer and walks a buffer address range for the selected pass. It drives one address beat per enabled, unstalled cycle, ascending for forward passes and descending for the backward pass. When the range is complete it returns the matching end strobe that advances the sequencer. It sits between the pass sequencer and the datapath buffer/memory.

## Interface
- ADDR_W, 4, address width.
- F0_LEN, 8, beats in forward-0 pass; legal range 1..2^ADDR_W.
- F1_LEN, 8, beats in forward-1 pass; legal range 1..2^ADDR_W.
- B_LEN, 8, beats in backward pass; legal range 1..2^ADDR_W.

- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- en_i  in  1  global enable; when low, all state, counters and registered outputs hold.
- f0_pass_i  in  1  forward-0 pass select (level).
- f1_pass_i  in  1  forward-1 pass select (level).
- b_pass_i  in  1  backward pass select (level).
- stall_i  in  1  datapath back-pressure; blocks beat issue.
- addr_o  out  ADDR_W  current beat address.
- valid_o  out  1  beat issued this cycle.
- dir_o  out  1  0 = ascending/forward, 1 = descending/backward.
- pass_id_o  out  2  00 none, 01 f0, 10 f1, 11 b.
- f0_end_o, f1_end_o, b_end_o  out  1 each  pass-complete strobes.
- busy_o  out  1  high in RUN.
- err_o  out  1  sticky illegal-select flag.

## Operation
- States:
  - IDLE: pass_id_o = 00; addr_o = 0.
  - RUN: one beat issued per enabled, unstalled cycle.
  - DONE: end strobe driven.
  - HOLD: waits for the sequencer to drop the pass select.
- State changes only on cycles with en_i = 1.
- IDLE, exactly one select high: latch pass_id_o and dir_o (1 only for b), load addr_o (0 for forward, LEN-1 for backward), enter RUN.
- IDLE, more than one select high: set err_o, stay in IDLE. err_o clears only on reset.
- RUN: valid_o = en_i & ~stall_i.
  - Each valid beat advances addr_o by +1 (forward) or -1 (backward).
  - The beat at address LEN-1 (forward) or 0 (backward) is the last; the next state is DONE with no further address step.
- RUN, latched select drops: abort to IDLE. No end strobe, err_o unchanged, addr_o returns to 0.
- DONE: the end strobe for the latched pass is high; all others are low. Leave DONE for HOLD on the first en_i cycle.
- HOLD: no beats, no strobes. Go to IDLE once the latched select is low, so a still-high select never re-runs the same pass. A different select that is already high is accepted from IDLE on the following cycle.
- Address arithmetic is ADDR_W bits. The counter never wraps because the last-beat compare stops it first.

## Timing
- Reset values: state IDLE, addr_o 0, valid_o 0, dir_o 0, pass_id_o 00, all end strobes 0, busy_o 0, err_o 0.
- Reset asserted mid-RUN forces the reset values immediately (asynchronous). Operation restarts from IDLE after release.
- Latency, no stalls, en_i = 1, select sampled high in IDLE at cycle t:
  - beats on cycles t+1 .. t+LEN;
  - end strobe on cycle t+LEN+1, for exactly 1 cycle;
  - HOLD from t+LEN+2.
- Each stalled or en_i-low cycle in RUN delays every later beat and the strobe by one cycle. addr_o holds during those cycles.
- With en_i low in DONE, the strobe stays high until the next en_i cycle, so the sequencer always samples it.
- All outputs are registered or decoded from state only. No combinational path from the select inputs to the outputs.

## Test plan
- f0 pass, F0_LEN=8, no stall: f0_pass_i high from cycle 0 -> valid_o with addr_o 0..7 on cycles 1-8, dir_o=0, pass_id_o=01; f0_end_o=1 on cycle 9 only.
- b pass, B_LEN=8 -> addr_o 7,6..0 on cycles 1-8, dir_o=1; b_end_o on cycle 9; f0_end_o and f1_end_o stay 0.
- f1 pass with stall_i high on cycles 3-4 -> addr_o holds at 2 for cycles 3-5, valid_o low on cycles 3-4; f1_end_o on cycle 11.
- f0_pass_i and b_pass_i high together in IDLE -> err_o=1 from next cycle and stays set; valid_o stays 0; no strobe.
- Select held high after the end strobe -> HOLD, no second run. Drop f0, raise f1 -> f1 run starts with addr_o=0 and pass_id_o=10.
- Abort: drop f0_pass_i at addr_o=3 -> IDLE, no f0_end_o. Separately, rst_i low mid-RUN -> all outputs at reset values in the same cycle.
